vga_pattern_gen: RTL and testbench

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pattern_pkg.sv | 40 ++++
 rtl/vga_pattern_gen_seg.sv | 55 +++++
 rtl/vga_pattern_gen.sv | 168 ++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pattern_pkg.sv
// Mode encodings and colour helpers shared by the VGA test-pattern generator.
// Component helpers take the bits-per-colour count and return a 10-bit value.
package vga_pattern_pkg;

    localparam logic [2:0] MODE_BARS  = 3'd0;
    localparam logic [2:0] MODE_CHECK = 3'd1;
    localparam logic [2:0] MODE_RAMP  = 3'd2;
    localparam logic [2:0] MODE_SOLID = 3'd3;
    localparam logic [2:0] MODE_HATCH = 3'd4;

    function automatic logic [9:0] comp_full(input int bpc);
        return 10'((1 << bpc) - 1);
    endfunction

    function automatic logic [9:0] comp_34(input int bpc);
        return 10'(3 << (bpc - 2));
    endfunction

    function automatic logic [9:0] ramp_comp(input int bpc,
                                             input logic [3:0] s);
        return 10'({6'd0, s} << (bpc - 4));
    endfunction

    // {R,G,B} enables for the eight bars, brightest to darkest.
    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        logic [2:0] m;
        case (idx)
            3'd0:    m = 3'b111;
            3'd1:    m = 3'b110;
            3'd2:    m = 3'b011;
            3'd3:    m = 3'b010;
            3'd4:    m = 3'b101;
            3'd5:    m = 3'b100;
            3'd6:    m = 3'b001;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_seg.sv
// Saturating segment index across a line; segment size is latched on clear.
// Index tracks the pixel at the current horizontal position.
module vga_seg_counter
    import vga_pattern_pkg::*;
#(
    parameter int HW    = 12,
    parameter int LOG2N = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [HW-1:0]    extent_i,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [LOG2N-1:0] idx_o
);

    localparam logic [LOG2N-1:0] IDX_MAX = '1;

    logic [HW-1:0]    ext_q, ext_d;
    logic [HW-1:0]    cnt_q, cnt_d;
    logic [LOG2N-1:0] idx_q, idx_d;

    always_comb begin
        ext_d = ext_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (clear_i) begin
            ext_d = extent_i;
            cnt_d = '0;
            idx_d = '0;
        end else if (advance_i && idx_q != IDX_MAX) begin
            if (cnt_q == ext_q - 1'b1) begin
                cnt_d = '0;
                idx_d = idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ext_q <= '0;
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            ext_q <= ext_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: bars, checkerboard, ramp, solid, cross-hatch.
// Define VGA_PATTERN_SCROLL_EN to scroll checkerboard/hatch by one pixel per frame.
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int BPC       = 8,
    parameter int HW        = 12,
    parameter int VW        = 12,
    parameter int CHK_LOG2  = 5,
    parameter int GRID_LOG2 = 6
) (
    input  logic             i_pixclk,
    input  logic             i_reset_n,
    input  logic [HW-1:0]    i_width,
    input  logic [VW-1:0]    i_height,
    input  logic [2:0]       i_mode,
    input  logic [3*BPC-1:0] i_color,
    input  logic             i_rd,
    input  logic             i_newline,
    input  logic             i_newframe,
    output logic [3*BPC-1:0] o_pixel
);

    localparam logic [BPC-1:0] L34  = BPC'(comp_34(BPC));
    localparam logic [BPC-1:0] FULL = BPC'(comp_full(BPC));
    localparam int XW = (CHK_LOG2 + 1 > GRID_LOG2) ? CHK_LOG2 + 1 : GRID_LOG2;

    logic [HW-1:0]    hpos_q, hpos_d;
    logic [VW-1:0]    ypos_q, ypos_d;
    logic [HW-1:0]    wid_q, wid_d;
    logic [VW-1:0]    hgt_q, hgt_d;
    logic [2:0]       mode_q, mode_d;
    logic             run_q, run_d;
    logic             seen_q, seen_d;
    logic [3*BPC-1:0] pix_q, pix_d;

    logic ev_nf, ev_nl, ev_rd, ln_clr;
    logic [2:0] bar_idx;
    logic [3:0] ramp_idx;
    logic [XW-1:0] xs;
    logic border;
    logic [2:0] m;
    logic [BPC-1:0] gray;
    logic [3*BPC-1:0] pat;

    assign ev_nf  = i_newframe;
    assign ev_nl  = !i_newframe && i_newline;
    assign ev_rd  = !i_newframe && !i_newline && i_rd;
    assign ln_clr = i_newframe || i_newline;

    vga_seg_counter #(.HW(HW), .LOG2N(3)) u_bar_seg (
        .clk_i     (i_pixclk),
        .rst_ni    (i_reset_n),
        .extent_i  (i_width >> 3),
        .clear_i   (ln_clr),
        .advance_i (ev_rd),
        .idx_o     (bar_idx)
    );

    vga_seg_counter #(.HW(HW), .LOG2N(4)) u_ramp_seg (
        .clk_i     (i_pixclk),
        .rst_ni    (i_reset_n),
        .extent_i  (i_width >> 4),
        .clear_i   (ln_clr),
        .advance_i (ev_rd),
        .idx_o     (ramp_idx)
    );

`ifdef VGA_PATTERN_SCROLL_EN
    logic [HW-1:0] off_q, off_d;

    assign off_d = ev_nf ? off_q + 1'b1 : off_q;
    assign xs    = hpos_q[XW-1:0] + off_q[XW-1:0];

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) off_q <= '0;
        else            off_q <= off_d;
    end
`else
    assign xs = hpos_q[XW-1:0];
`endif

    always_comb begin
        hpos_d = hpos_q;
        ypos_d = ypos_q;
        wid_d  = wid_q;
        hgt_d  = hgt_q;
        mode_d = mode_q;
        run_d  = run_q;
        seen_d = seen_q;
        if (ln_clr) begin
            hpos_d = '0;
            wid_d  = i_width;
            hgt_d  = i_height;
            seen_d = 1'b0;
        end
        if (ev_nf) begin
            ypos_d = '0;
            mode_d = i_mode;
            run_d  = 1'b1;
        end else if (ev_nl) begin
            if (seen_q && ypos_q != '1) ypos_d = ypos_q + 1'b1;
        end else if (ev_rd) begin
            seen_d = 1'b1;
            if (hpos_q != '1) hpos_d = hpos_q + 1'b1;
        end
    end

    assign border = (hpos_q == '0) || (hpos_q == wid_q - 1'b1) ||
                    (ypos_q == '0) || (ypos_q == hgt_q - 1'b1);

    assign m    = bar_mask(bar_idx);
    assign gray = BPC'(ramp_comp(BPC, ramp_idx));

    always_comb begin
        pat = '0;
        case (mode_q)
            MODE_BARS:
                pat = {{BPC{m[2]}} & L34, {BPC{m[1]}} & L34, {BPC{m[0]}} & L34};
            MODE_CHECK:
                pat = (xs[CHK_LOG2] ^ ypos_q[CHK_LOG2]) ? '1 : '0;
            MODE_RAMP:
                pat = {gray, gray, gray};
            MODE_SOLID:
                pat = i_color;
            MODE_HATCH:
                pat = (xs[GRID_LOG2-1:0] == '0 ||
                       ypos_q[GRID_LOG2-1:0] == '0) ? '1 : '0;
            default:
                pat = '0;
        endcase
    end

    // Output stays black after reset until a frame start has been seen.
    always_comb begin
        pix_d = pix_q;
        if (ev_rd) begin
            if (!run_q)      pix_d = '0;
            else if (border) pix_d = {FULL, FULL, FULL};
            else             pix_d = pat;
        end
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hpos_q <= '0;
            ypos_q <= '0;
            wid_q  <= '0;
            hgt_q  <= '0;
            mode_q <= '0;
            run_q  <= 1'b0;
            seen_q <= 1'b0;
            pix_q  <= '0;
        end else begin
            hpos_q <= hpos_d;
            ypos_q <= ypos_d;
            wid_q  <= wid_d;
            hgt_q  <= hgt_d;
            mode_q <= mode_d;
            run_q  <= run_d;
            seen_q <= seen_d;
            pix_q  <= pix_d;
        end
    end

    assign o_pixel = pix_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen at BPC=8, default geometry parameters.
module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] wid;
    logic [11:0] hgt;
    logic [2:0]  mode;
    logic [23:0] color;
    logic        rd, nl, nf;
    logic [23:0] pix;

    always #5 clk = ~clk;

    vga_pattern_gen dut (
        .i_pixclk   (clk),
        .i_reset_n  (rst_n),
        .i_width    (wid),
        .i_height   (hgt),
        .i_mode     (mode),
        .i_color    (color),
        .i_rd       (rd),
        .i_newline  (nl),
        .i_newframe (nf),
        .o_pixel    (pix)
    );

    typedef struct {
        bit          chk;
        logic [23:0] e;
        string       nm;
    } ent_t;

    ent_t sb[$];
    logic obs   = 1'b0;
    logic obs_q = 1'b0;
    int   nrun  = 0;
    int   nfail = 0;
    int   h     = 0;

    always @(posedge clk) obs_q <= obs;

    always @(negedge clk) begin : mon
        ent_t t;
        if (obs_q) begin
            if (sb.size() == 0) begin
                nrun++;
                nfail++;
                $display("FAIL sb_underflow: no expected entry queued");
            end else begin
                t = sb.pop_front();
                if (t.chk) begin
                    nrun++;
                    if (pix !== t.e) begin
                        nfail++;
                        $display("FAIL %s: got %06h want %06h", t.nm, pix, t.e);
                    end
                end
            end
        end
    end

    task automatic step(input logic r, input logic l, input logic f,
                        input bit c, input logic [23:0] e, input string n);
        ent_t t;
        @(negedge clk);
        rd  = r;
        nl  = l;
        nf  = f;
        obs = c || (r && !l && !f);
        if (obs) begin
            t.chk = c;
            t.e   = e;
            t.nm  = n;
            sb.push_back(t);
        end
        if (l || f) h = 0;
        else if (r) h++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, "");
    endtask

    task automatic newline();
        step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0, "");
    endtask

    task automatic newframe();
        step(1'b0, 1'b0, 1'b1, 1'b0, 24'h0, "");
    endtask

    task automatic px(input int x, input logic [23:0] e, input string n);
        while (h < x) step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, "");
        step(1'b1, 1'b0, 1'b0, 1'b1, e, n);
    endtask

    initial begin
        rst_n = 1'b0;
        wid   = 12'd640;
        hgt   = 12'd480;
        mode  = 3'd0;
        color = 24'h0;
        rd    = 1'b0;
        nl    = 1'b0;
        nf    = 1'b0;

        step(1'b1, 1'b0, 1'b0, 1'b1, 24'h000000, "reset_pix");
        idle();
        rst_n = 1'b1;
        h = 0;
        px(0, 24'h000000, "pre_nf_x0");
        px(3, 24'h000000, "pre_nf_x3");

        newframe();
        px(5, 24'hFFFFFF, "bars_y0");
        newline();
        px(0,   24'hFFFFFF, "bars_x0");
        px(1,   24'hC0C0C0, "bars_x1");
        px(79,  24'hC0C0C0, "bars_x79");
        mode  = 3'd3;
        color = 24'h123456;
        px(80,  24'hC0C000, "bars_x80");
        px(160, 24'h00C0C0, "bars_x160");
        px(639, 24'hFFFFFF, "bars_x639");
        step(1'b1, 1'b1, 1'b0, 1'b1, 24'hFFFFFF, "hold_rd_nl");
        px(1,   24'hC0C0C0, "nl_hpos_clr");

        hgt = 12'd7;
        newline();
        newline();
        newline();
        newline();
        px(1, 24'hC0C0C0, "nl_no_rd");
        hgt = 12'd4;
        px(2, 24'hC0C0C0, "h_mid_nofx");
        hgt = 12'd5;
        newline();
        px(1, 24'hFFFFFF, "h_at_nl");
        hgt = 12'd480;
        newline();
        px(700,  24'h000000, "bar_remainder");
        px(4096, 24'h000000, "hpos_sat");

        newframe();
        px(1, 24'hFFFFFF, "solid_y0");
        newline();
        px(1,   24'h123456, "solid_x1");
        px(300, 24'h123456, "solid_x300");

        mode = 3'd2;
        newframe();
        px(1, 24'hFFFFFF, "ramp_y0");
        newline();
        px(1,   24'h000000, "ramp_s0");
        px(40,  24'h101010, "ramp_s1");
        px(200, 24'h505050, "ramp_s5");
        wid = 12'd320;
        px(635, 24'hF0F0F0, "ramp_s15");
        px(639, 24'hFFFFFF, "w_mid_nofx");
        newline();
        px(100, 24'h505050, "ramp_w320");
        px(319, 24'hFFFFFF, "w320_edge");

        wid  = 12'd640;
        mode = 3'd1;
        newframe();
        px(1, 24'hFFFFFF, "chk_y0");
        newline();
        px(1,  24'h000000, "chk_x1");
        px(32, 24'hFFFFFF, "chk_x32");
        px(64, 24'h000000, "chk_x64");

        mode = 3'd4;
        newframe();
        px(1, 24'hFFFFFF, "hatch_y0");
        newline();
        px(1,  24'h000000, "hatch_x1");
        px(64, 24'hFFFFFF, "hatch_x64");
        px(65, 24'h000000, "hatch_x65");

        mode = 3'd5;
        newframe();
        px(1, 24'hFFFFFF, "mode5_y0");
        newline();
        px(64, 24'h000000, "mode5_x64");

        mode = 3'd3;
        newframe();
        px(1, 24'hFFFFFF, "rst_y0");
        newline();
        px(10, 24'h123456, "rst_pre");
        idle();
        idle();
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b1, 24'h000000, "rst_mid");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, "");
        idle();
        rst_n = 1'b1;
        h = 0;
        px(0, 24'h000000, "rst_black_x0");
        px(5, 24'h000000, "rst_black_x5");
        newframe();
        px(1, 24'hFFFFFF, "rst_nf_y0");
        newline();
        px(1, 24'h123456, "rst_nf_solid");

        idle();
        idle();
        idle();
        if (sb.size() != 0) begin
            nrun++;
            nfail++;
            $display("FAIL sb_drain: got %0d left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
